// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences the video PLL reset and holds downstream logic in reset until the
// PLL lock has been continuously stable. Lock is resynchronised to refclk;
// every output is a flop updated on the same edge as the state register.
// Build option: define PLL_SUP_LOSS_COUNT_EN to implement the saturating
// loss_count; otherwise loss_count is tied to zero.
//
// state       | meaning
// ------------+------------------------------------------------------------
// PLL_RESET   | pll_rst high for RST_CYCLES cycles
// WAIT_LOCK   | pll_rst low, waiting for locked_s, retry after LOCK_TIMEOUT
// STABLE      | locked_s must stay high for STABLE_CYCLES cycles
// RUN         | downstream released; loss of lock restarts the PLL

module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] loss_count
);

    typedef enum logic [3:0] {
        S_PLL_RESET = 4'b0001,
        S_WAIT_LOCK = 4'b0010,
        S_STABLE    = 4'b0100,
        S_RUN       = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, locked_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;

    // Next-state, shared counter and registered output values.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PLL_RESET: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s_q)                  state_d = S_STABLE;
                else if (cnt_q == TIMEOUT_LAST)  state_d = S_PLL_RESET;
            end
            S_STABLE: begin
                if (!locked_s_q)                 state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)   state_d = S_RUN;
            end
            S_RUN: begin
                if (!locked_s_q) state_d = S_PLL_RESET;
            end
            default: state_d = S_PLL_RESET;
        endcase
        cnt_d     = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        pll_rst_d = (state_d == S_PLL_RESET);
        sys_rst_d = (state_d != S_RUN);
    end

    // State, counter, lock synchroniser and output flops.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= S_PLL_RESET;
            cnt_q      <= '0;
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            pll_rst_q  <= 1'b1;
            sys_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync1_q    <= locked;
            locked_s_q <= sync1_q;
            pll_rst_q  <= pll_rst_d;
            sys_rst_q  <= sys_rst_d;
        end
    end

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ~sys_rst_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
    logic       loss_event;
    logic [7:0] loss_count_q, loss_count_d;

    assign loss_event = (state_q == S_RUN) && !locked_s_q;

    // Saturating count of lock losses seen while released.
    always_comb begin
        loss_count_d = loss_count_q;
        if (loss_event && (loss_count_q != 8'hFF)) loss_count_d = loss_count_q + 8'd1;
    end

    // Loss counter flop, cleared by reset.
    always_ff @(posedge refclk) begin
        if (rst) loss_count_q <= 8'd0;
        else     loss_count_q <= loss_count_d;
    end

    assign loss_count = loss_count_q;
`else
    assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with short timing parameters. A mode/age
// model predicts the outputs every cycle; directed sequences pin key timings.
module tb_pll_lock_supervisor;

    localparam int RST_C = 4;
    localparam int TO_C  = 32;
    localparam int ST_C  = 8;
`ifdef PLL_SUP_LOSS_COUNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready;
    logic [7:0] loss_count;

    int n_total = 0;
    int n_bad   = 0;

    pll_lock_supervisor #(
        .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(ST_C), .CNT_W(20)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .loss_count(loss_count)
    );

    always #10 refclk = ~refclk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = PLL held in reset, 1 = waiting for lock, 2 = proving
    // stability, 3 = released. age = cycles completed in the current mode.
    int m_mode = 0, m_prev = 0, m_age = 0, m_loss = 0;
    bit m_s1 = 0, m_s2 = 0, m_valid = 0;

    always @(posedge refclk) begin
        if (rst) begin
            m_mode = 0; m_age = 0; m_s1 = 0; m_s2 = 0; m_loss = 0; m_valid = 1;
        end else begin
            m_prev = m_mode;
            m_age  = m_age + 1;
            if (m_mode == 0) begin
                if (m_age == RST_C) m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_s2) m_mode = 2;
                else if (m_age == TO_C) m_mode = 0;
            end else if (m_mode == 2) begin
                if (!m_s2) m_mode = 1;
                else if (m_age == ST_C) m_mode = 3;
            end else begin
                if (!m_s2) begin
                    m_mode = 0;
                    if (m_loss < 255) m_loss = m_loss + 1;
                end
            end
            if (m_mode != m_prev) m_age = 0;
            m_s2 = m_s1;
            m_s1 = locked;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge refclk) begin
        if (m_valid) begin
            chk("model_pll_rst", pll_rst, (m_mode == 0) ? 1 : 0);
            chk("model_sys_rst", sys_rst, (m_mode == 3) ? 0 : 1);
            chk("model_ready", ready, (m_mode == 3) ? 1 : 0);
            chk("model_loss_count", loss_count, LC_EN ? m_loss : 0);
        end
    end

    task automatic step();
        @(posedge refclk);
        #2;
    endtask

    task automatic wait_pll_low(input string name);
        int n = 0;
        while (pll_rst && n < 100) begin step(); n++; end
        chk(name, pll_rst, 0);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 100) begin step(); n++; end
        chk(name, ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit sys_seen_low;
        bit pll_seen_high;

        // Reset state
        rst = 1'b1; locked = 1'b0;
        repeat (3) step();
        chk("reset_pll_rst", pll_rst, 1);
        chk("reset_sys_rst", sys_rst, 1);
        chk("reset_ready", ready, 0);
        chk("reset_loss_count", loss_count, 0);
        rst = 1'b0;

        // No lock: pulse 4 high, 32 low, repeating; never released
        sys_seen_low = 0;
        wait_pll_low("first_pll_fall");
        n = 0;
        do begin step(); n++; if (!sys_rst) sys_seen_low = 1; end while (!pll_rst && n < 100);
        chk("wait_lock_low_width", n, TO_C);
        n = 0;
        do begin step(); n++; if (!sys_rst) sys_seen_low = 1; end while (pll_rst && n < 100);
        chk("pll_rst_pulse_width", n, RST_C);
        chk("no_lock_sys_rst_held", sys_seen_low, 0);

        // Lock rises 10 cycles into WAIT_LOCK; release 10 edges after first sample
        repeat (9) step();
        locked = 1'b1;
        step();
        n = 0;
        do begin step(); n++; end while (sys_rst && n < 100);
        chk("lock_to_release_edges", n, 2 + ST_C);
        chk("release_ready", ready, 1);

        // Loss of lock in RUN, repeated until the counter saturates
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            step();
            step();
            if (i == 0) chk("run_exit_k1_sys_rst", sys_rst, 0);
            step();
            if (i == 0) begin
                chk("run_exit_k2_sys_rst", sys_rst, 1);
                chk("run_exit_k2_pll_rst", pll_rst, 1);
                chk("run_exit_loss_count", loss_count, LC_EN ? 1 : 0);
            end
            locked = 1'b1;
            wait_ready("relock_ready");
        end
        chk("loss_count_saturated", loss_count, LC_EN ? 255 : 0);

        // One-cycle rst while in RUN
        rst = 1'b1; locked = 1'b0;
        step();
        chk("rst_run_sys_rst", sys_rst, 1);
        chk("rst_run_pll_rst", pll_rst, 1);
        chk("rst_run_ready", ready, 0);
        chk("rst_run_loss_count", loss_count, 0);
        rst = 1'b0;
        n = 0;
        do begin step(); n++; end while (pll_rst && n < 100);
        chk("restart_pulse_width", n, RST_C);

        // One-cycle drop of lock while in STABLE at count 5
        locked = 1'b1;
        repeat (6) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        step();
        pll_seen_high = 0;
        n = 0;
        do begin step(); n++; if (pll_rst) pll_seen_high = 1; end while (sys_rst && n < 100);
        chk("glitch_release_edges", n, 2 + ST_C);
        chk("glitch_no_pll_rst", pll_seen_high, 0);
        chk("glitch_loss_not_counted", loss_count, 0);

        repeat (5) step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
